counter_checker: RTL and testbench

- Receiving end of the 32-bit counter interface: passively observes the stimulus (enable, mode, D) driven into the counter and the counter's responses (Q, rco, load).
- Runs a cycle-accurate reference model of the counter and compares the model against the counter's responses every cycle.
- Reports mismatches, error and check counts, and a pass/fail status.
- Instantiated beside the counter DUT in the top-level harness. It drives nothing into the DUT.

---
 rtl/counter_checker_pkg.sv | 18 +
 rtl/counter_checker_if.sv | 21 ++
 rtl/counter_ref_model.sv | 58 +++++
 rtl/counter_checker.sv | 112 +++++++++++
 tb/tb_counter_checker.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_checker_pkg.sv
// rtl/counter_checker_pkg.sv - shared mode and FSM state encodings for the counter checker
package counter_checker_pkg;

  typedef enum logic [1:0] {
    MODE_UP1  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_DN3  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Encoding 2'b11 is deliberately unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

endpackage

// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - observed counter stimulus/response bus (master drives, slave observes)
interface counter_checker_if #(
  parameter int WIDTH = 32
) ();

  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D_32b;
  logic [WIDTH-1:0] Q_32b;
  logic             rco_32b;
  logic             load_32b;

  modport master (
    output enable, mode, D_32b, Q_32b, rco_32b, load_32b
  );

  modport slave (
    input enable, mode, D_32b, Q_32b, rco_32b, load_32b
  );

endinterface

// File: rtl/counter_ref_model.sv
// rtl/counter_ref_model.sv - cycle-accurate predictive model of the 32-bit counter
module counter_ref_model
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             load
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
    end else if (!hold) begin
      if (!enable) begin
        rco  <= 1'b0;
        load <= 1'b0;
      end else begin
        case (mode_t'(mode))
          MODE_UP1: begin
            q    <= q + ONE;
            rco  <= (q == '1);
            load <= 1'b0;
          end
          MODE_DN1: begin
            q    <= q - ONE;
            rco  <= (q == '0);
            load <= 1'b0;
          end
          MODE_DN3: begin
            // rco doubles as the borrow flag when stepping down by three
            q    <= q - THREE;
            rco  <= (q < THREE);
            load <= 1'b0;
          end
          default: begin
            q    <= d;
            rco  <= 1'b0;
            load <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive counter checker; optional failure capture via COUNTER_CHECKER_CAPTURE_EN
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  counter_checker_if.slave  mon,
  output logic [WIDTH-1:0]  exp_q,
  output logic              mismatch,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  chk_count,
  output logic [1:0]        state,
  output logic              done,
  output logic [WIDTH-1:0]  fail_exp,
  output logic [WIDTH-1:0]  fail_got,
  output logic [CNT_W-1:0]  fail_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic [WIDTH-1:0] m_q;
  logic             m_rco;
  logic             m_load;
  logic             miss;
  logic [CNT_W-1:0] chk_next;
  logic [CNT_W-1:0] err_next;

  counter_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .clk    (clk),
    .rst_n  (reset),
    .hold   (st == ST_HALT),
    .enable (mon.enable),
    .mode   (mon.mode),
    .d      (mon.D_32b),
    .q      (m_q),
    .rco    (m_rco),
    .load   (m_load)
  );

  // Case inequality so that X/Z on the DUT outputs is flagged rather than masked
  assign miss = ({mon.Q_32b, mon.rco_32b, mon.load_32b} !== {m_q, m_rco, m_load});

  assign chk_next = (chk_count == CNT_MAX) ? chk_count : chk_count + 1'b1;
  assign err_next = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;

  assign exp_q = m_q;
  assign state = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      mismatch  <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
      done      <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (mon.enable) st <= ST_CHECK;
        end
        ST_CHECK: begin
          chk_count <= chk_next;
          if (miss) begin
            mismatch  <= 1'b1;
            err_flag  <= 1'b1;
            err_count <= err_next;
            if (HALT_ON_ERR != 0) begin
              st   <= ST_HALT;
              done <= 1'b1;
            end
          end
        end
        ST_HALT: begin
        end
        default: begin
          st   <= ST_IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CHECKER_CAPTURE_EN
  // Only the first mismatch after reset is latched; err_flag marks that it happened
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_exp <= '0;
      fail_got <= '0;
      fail_idx <= '0;
    end else if (st == ST_CHECK && miss && !err_flag) begin
      fail_exp <= m_q;
      fail_got <= mon.Q_32b;
      fail_idx <= chk_next;
    end
  end
`else
  assign fail_exp = '0;
  assign fail_got = '0;
  assign fail_idx = '0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - scoreboard bench for counter_checker (normal, 3-bit saturating, halt-on-error)
module tb_counter_checker;

  typedef struct {
    int          st;
    logic [31:0] eq;
    bit          mm;
    bit          ef;
    bit          done;
    int          ec;
    int          cc;
    logic [31:0] fexp;
    logic [31:0] fgot;
    int          fidx;
  } mdl_t;

  typedef struct {
    mdl_t i [3];
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(32)) bus ();

  logic [31:0] exq [3];
  logic        mm  [3];
  logic        ef  [3];
  logic [1:0]  stv [3];
  logic        dn  [3];
  logic [31:0] fe  [3];
  logic [31:0] fg  [3];
  logic [15:0] ec  [3];
  logic [15:0] cc  [3];
  logic [15:0] fi  [3];
  logic [2:0]  ec_s, cc_s, fi_s;

  assign ec[1] = {13'b0, ec_s};
  assign cc[1] = {13'b0, cc_s};
  assign fi[1] = {13'b0, fi_s};

  counter_checker #(.WIDTH(32), .CNT_W(16), .HALT_ON_ERR(0)) u_main (
    .clk(clk), .reset(reset), .mon(bus),
    .exp_q(exq[0]), .mismatch(mm[0]), .err_flag(ef[0]), .err_count(ec[0]),
    .chk_count(cc[0]), .state(stv[0]), .done(dn[0]),
    .fail_exp(fe[0]), .fail_got(fg[0]), .fail_idx(fi[0])
  );

  counter_checker #(.WIDTH(32), .CNT_W(3), .HALT_ON_ERR(0)) u_sat (
    .clk(clk), .reset(reset), .mon(bus),
    .exp_q(exq[1]), .mismatch(mm[1]), .err_flag(ef[1]), .err_count(ec_s),
    .chk_count(cc_s), .state(stv[1]), .done(dn[1]),
    .fail_exp(fe[1]), .fail_got(fg[1]), .fail_idx(fi_s)
  );

  counter_checker #(.WIDTH(32), .CNT_W(16), .HALT_ON_ERR(1)) u_halt (
    .clk(clk), .reset(reset), .mon(bus),
    .exp_q(exq[2]), .mismatch(mm[2]), .err_flag(ef[2]), .err_count(ec[2]),
    .chk_count(cc[2]), .state(stv[2]), .done(dn[2]),
    .fail_exp(fe[2]), .fail_got(fg[2]), .fail_idx(fi[2])
  );

  int    total  = 0;
  int    passed = 0;
  mdl_t  md [3];
  int    cmax [3] = '{65535, 7, 65535};
  bit    hoe  [3] = '{1'b0, 1'b0, 1'b1};
  snap_t sb [$];
  snap_t ms;

  // The spec counter as driven onto the bus (the "correct DUT")
  logic [31:0] tq;
  bit          trco, tload;

  task automatic chk(input string nm, input int inst, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, inst, $time, got, exp);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ms = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("exp_q",     i, 64'(exq[i]), 64'(ms.i[i].eq));
        chk("mismatch",  i, 64'(mm[i]),  64'(ms.i[i].mm));
        chk("err_flag",  i, 64'(ef[i]),  64'(ms.i[i].ef));
        chk("err_count", i, 64'(ec[i]),  64'(ms.i[i].ec));
        chk("chk_count", i, 64'(cc[i]),  64'(ms.i[i].cc));
        chk("state",     i, 64'(stv[i]), 64'(ms.i[i].st));
        chk("done",      i, 64'(dn[i]),  64'(ms.i[i].done));
        chk("fail_exp",  i, 64'(fe[i]),  64'(ms.i[i].fexp));
        chk("fail_got",  i, 64'(fg[i]),  64'(ms.i[i].fgot));
        chk("fail_idx",  i, 64'(fi[i]),  64'(ms.i[i].fidx));
      end
    end
  end

  // Inputs drive the bus for one cycle; expected checker state after the next edge is queued
  task automatic step(input bit en, input logic [1:0] m, input logic [31:0] d,
                      input logic [31:0] qx, input bit rx, input bit lx, input bit xq);
    logic [31:0] dq, nq;
    bit          nr, nl, miss;
    snap_t       s;
    dq = xq ? 32'bx : (tq ^ qx);
    bus.enable   = en;
    bus.mode     = m;
    bus.D_32b    = d;
    bus.Q_32b    = dq;
    bus.rco_32b  = trco ^ rx;
    bus.load_32b = tload ^ lx;
    miss = ({dq, trco ^ rx, tload ^ lx} !== {tq, trco, tload});
    nq = tq; nr = 0; nl = 0;
    if (en) begin
      case (m)
        2'd0: begin nq = tq + 32'd1; nr = (tq == 32'hFFFF_FFFF); end
        2'd1: begin nq = tq - 32'd1; nr = (tq == 32'd0); end
        2'd2: begin nq = tq - 32'd3; nr = (tq < 32'd3); end
        default: begin nq = d; nl = 1; end
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      md[i].mm = 0;
      if (md[i].st != 2) md[i].eq = nq;
      if (md[i].st == 0) begin
        if (en) md[i].st = 1;
      end else if (md[i].st == 1) begin
        if (md[i].cc < cmax[i]) md[i].cc++;
        if (miss) begin
`ifdef COUNTER_CHECKER_CAPTURE_EN
          if (!md[i].ef) begin
            md[i].fexp = tq;
            md[i].fgot = dq;
            md[i].fidx = md[i].cc;
          end
`endif
          md[i].mm = 1;
          md[i].ef = 1;
          if (md[i].ec < cmax[i]) md[i].ec++;
          if (hoe[i]) begin md[i].st = 2; md[i].done = 1; end
        end
      end
    end
    @(posedge clk);
    s.i = md;
    sb.push_back(s);
    tq = nq; trco = nr; tload = nl;
    #1;
  endtask

  task automatic clean(input bit en, input logic [1:0] m, input logic [31:0] d);
    step(en, m, d, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserted mid-cycle once the scoreboard has drained; outputs must clear without a clock
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_exp_q",     i, 64'(exq[i]), 64'd0);
      chk("rst_mismatch",  i, 64'(mm[i]),  64'd0);
      chk("rst_err_flag",  i, 64'(ef[i]),  64'd0);
      chk("rst_err_count", i, 64'(ec[i]),  64'd0);
      chk("rst_chk_count", i, 64'(cc[i]),  64'd0);
      chk("rst_state",     i, 64'(stv[i]), 64'd0);
      chk("rst_done",      i, 64'(dn[i]),  64'd0);
      md[i] = '{st: 0, eq: 32'd0, mm: 0, ef: 0, done: 0, ec: 0, cc: 0,
                fexp: 32'd0, fgot: 32'd0, fidx: 0};
    end
    tq = 32'd0; trco = 0; tload = 0;
    bus.enable = 0; bus.mode = 2'd0; bus.D_32b = 32'd0;
    bus.Q_32b = 32'd0; bus.rco_32b = 0; bus.load_32b = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 0; bus.mode = 2'd0; bus.D_32b = 32'd0;
    bus.Q_32b = 32'd0; bus.rco_32b = 0; bus.load_32b = 0;
    tq = 32'd0; trco = 0; tload = 0;
    do_reset();

    // Two errors: rco at check 3 (halts u_halt), Q at check 7
    for (int k = 0; k < 18; k++) begin
      if (k == 3)      step(1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      else if (k == 7) step(1, 2'd0, 32'd0, 32'h10, 1'b0, 1'b0, 1'b0);
      else             clean(1, 2'd0, 32'd0);
    end

    do_reset();
    for (int k = 0; k < 5; k++) clean(1, 2'd0, 32'd0);
    clean(0, 2'd0, 32'd0);
    clean(1, 2'd3, 32'hFFFF_FFFF);
    clean(1, 2'd0, 32'd0);
    clean(0, 2'd0, 32'd0);
    for (int k = 0; k < 4; k++) clean(0, 2'($urandom_range(0, 3)), $urandom);
    clean(1, 2'd0, 32'd0);
    clean(1, 2'd2, 32'd0);
    step(0, 2'd0, 32'd0, 32'h1, 1'b0, 1'b0, 1'b0);
    clean(0, 2'd0, 32'd0);
    step(1, 2'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    clean(1, 2'd1, 32'd0);
    step(1, 2'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      bit          en;
      logic [1:0]  m;
      logic [31:0] d, qx;
      bit          rx, lx;
      int          r;
      en = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 3);
      if (r == 0)      d = $urandom_range(0, 4);
      else if (r == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
      else             d = $urandom;
      qx = 32'd0; rx = 0; lx = 0;
      r = $urandom_range(0, 15);
      if (r == 0)      qx = 32'd1 << $urandom_range(0, 31);
      else if (r == 1) rx = 1;
      else if (r == 2) lx = 1;
      step(en, m, d, qx, rx, lx, 1'b0);
    end

    do_reset();
    for (int k = 0; k < 3; k++) clean(1, 2'd2, 32'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
